// File: rtl/ir_grid_pkg.sv
// Shared constants, cell state encoding and helpers for the IR grid conditioner.
// Optional per-cell masking is built in when IR_GRID_MASK_EN is defined.
package ir_grid_pkg;

   localparam int NUM_CELLS = 16;
   localparam int DEF_TICK_DIV = 50000;
   localparam int DEF_DEBOUNCE_TICKS = 8;
   localparam int DEF_HOLD_TICKS = 100;

   typedef enum logic [1:0] {
      CELL_IDLE   = 2'd0,
      CELL_QUAL   = 2'd1,
      CELL_ACTIVE = 2'd2,
      CELL_HOLD   = 2'd3
   } cell_state_e;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Scan downwards so the lowest set bit wins.
   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = NUM_CELLS - 1; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ir_debounce_cell.sv
// One grid box: qualify a synced beam-break over several ticks, then
// stretch the accepted hit for a hold period after the beam clears.
import ir_grid_pkg::*;

module ir_debounce_cell #(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
   input  logic clk,
   input  logic reset,
   input  logic force_idle,
   input  logic level,
   input  logic tick,
   output logic hit
);

   cell_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic hit_q, hit_d;

   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      hit_d = (state_q == CELL_ACTIVE) || (state_q == CELL_HOLD);
      if (force_idle) begin
         state_d = CELL_IDLE;
         cnt_d = '0;
      end else begin
         unique case (state_q)
            CELL_IDLE: begin
               if (level) begin
                  state_d = CELL_QUAL;
                  cnt_d = '0;
               end
            end
            CELL_QUAL: begin
               // Level checks come first so a drop on a tick edge still aborts.
               if (!level) begin
                  state_d = CELL_IDLE;
                  cnt_d = '0;
               end else if (tick) begin
                  if (cnt_q == 8'(DEBOUNCE_TICKS - 1)) begin
                     state_d = CELL_ACTIVE;
                     cnt_d = '0;
                  end else begin
                     cnt_d = sat_inc(cnt_q);
                  end
               end
            end
            CELL_ACTIVE: begin
               if (!level) begin
                  state_d = CELL_HOLD;
                  cnt_d = '0;
               end
            end
            CELL_HOLD: begin
               if (level) begin
                  state_d = CELL_ACTIVE;
                  cnt_d = '0;
               end else if (tick) begin
                  if (cnt_q == 8'(HOLD_TICKS - 1)) begin
                     state_d = CELL_IDLE;
                     cnt_d = '0;
                  end else begin
                     cnt_d = sat_inc(cnt_q);
                  end
               end
            end
            default: begin
               state_d = CELL_IDLE;
               cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= CELL_IDLE;
         cnt_q <= '0;
         hit_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         hit_q <= hit_d;
      end
   end

   assign hit = hit_q;

endmodule

// File: rtl/ir_grid_conditioner.sv
// Conditions 16 active-low IR receivers into a debounced, stretched hit map.
// Define IR_GRID_MASK_EN to add the per-cell ir_mask input.
import ir_grid_pkg::*;

module ir_grid_conditioner #(
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] ir_raw,
`ifdef IR_GRID_MASK_EN
   input  logic [15:0] ir_mask,
`endif
   output logic [15:0] ir_in_p1,
   output logic        ir_any,
   output logic        hit_pulse,
   output logic [3:0]  ir_last_cell
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [15:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0] prev_q, prev_d;
   logic any_q, any_d;
   logic pulse_q, pulse_d;
   logic [3:0] last_q, last_d;
   logic tick;
   logic [15:0] force_idle, cell_hit, rise;

`ifdef IR_GRID_MASK_EN
   assign force_idle = {NUM_CELLS{~enable}} | ir_mask;
`else
   assign force_idle = {NUM_CELLS{~enable}};
`endif

   always_comb begin
      tick = (presc_q == PW'(TICK_DIV - 1));
      sync1_d = ~ir_raw;
      sync2_d = sync1_q;
      if (!enable || tick) presc_d = '0;
      else presc_d = presc_q + PW'(1);
      rise = cell_hit & ~prev_q;
      prev_d = cell_hit;
      any_d = |cell_hit;
      pulse_d = |rise;
      last_d = pulse_d ? lowest_idx(rise) : last_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
         prev_q <= '0;
         any_q <= 1'b0;
         pulse_q <= 1'b0;
         last_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         presc_q <= presc_d;
         prev_q <= prev_d;
         any_q <= any_d;
         pulse_q <= pulse_d;
         last_q <= last_d;
      end
   end

   for (genvar n = 0; n < NUM_CELLS; n++) begin : g_cell
      ir_debounce_cell #(
         .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
         .HOLD_TICKS(HOLD_TICKS)
      ) u_cell (
         .clk(clk),
         .reset(reset),
         .force_idle(force_idle[n]),
         .level(sync2_q[n]),
         .tick(tick),
         .hit(cell_hit[n])
      );
   end

   assign ir_in_p1 = cell_hit;
   assign ir_any = any_q;
   assign hit_pulse = pulse_q;
   assign ir_last_cell = last_q;

endmodule

// File: tb/tb_ir_grid_conditioner.sv
// Directed bench for ir_grid_conditioner with TICK_DIV=4, DEBOUNCE=3, HOLD=5.
// Expected latencies are bounded ranges derived from sync + tick phase.
module tb_ir_grid_conditioner;

   logic clk = 1'b0;
   logic reset, enable;
   logic [15:0] ir_raw;
`ifdef IR_GRID_MASK_EN
   logic [15:0] ir_mask;
`endif
   logic [15:0] ir_in_p1;
   logic ir_any, hit_pulse;
   logic [3:0] ir_last_cell;

   int n_chk = 0;
   int n_err = 0;
   int pulses = 0;
   int p0, n;
   logic seen;

   always #5 clk = ~clk;

   ir_grid_conditioner #(
      .TICK_DIV(4),
      .DEBOUNCE_TICKS(3),
      .HOLD_TICKS(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .ir_raw(ir_raw),
`ifdef IR_GRID_MASK_EN
      .ir_mask(ir_mask),
`endif
      .ir_in_p1(ir_in_p1),
      .ir_any(ir_any),
      .hit_pulse(hit_pulse),
      .ir_last_cell(ir_last_cell)
   );

   always @(negedge clk) if (hit_pulse) pulses++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycles until ir_in_p1[b] equals v; returns -1 on timeout.
   task automatic wait_bit(input int b, input logic v, input int maxc,
                           output int cyc);
      cyc = -1;
      for (int i = 1; i <= maxc; i++) begin
         step(1);
         if (ir_in_p1[b] === v) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic in_range(input string tag, input int v,
                           input int lo, input int hi);
      chk(tag, 32'((v >= lo) && (v <= hi)), 32'd1);
      if (v < lo || v > hi) $display("  %s latency %0d", tag, v);
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      ir_raw = 16'hFFFF;
`ifdef IR_GRID_MASK_EN
      ir_mask = '0;
`endif
      step(3);
      reset = 1'b0;
      step(1);
      chk("rst_map", 32'(ir_in_p1), 32'h0);
      chk("rst_any", 32'(ir_any), 32'h0);
      chk("rst_pulse", 32'(hit_pulse), 32'h0);
      chk("rst_last", 32'(ir_last_cell), 32'h0);

      // Idle grid
      p0 = pulses;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (ir_in_p1 != 0) seen = 1'b1;
      end
      chk("idle_map", 32'(seen), 32'h0);
      chk("idle_pulse", 32'(pulses - p0), 32'd0);

      // Glitch of 6 cycles is shorter than 3 ticks
      ir_raw[5] = 1'b0;
      step(6);
      ir_raw[5] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (ir_in_p1 != 0) seen = 1'b1;
      end
      chk("glitch", 32'(seen), 32'h0);

      // Steady break on box 5
      p0 = pulses;
      ir_raw[5] = 1'b0;
      wait_bit(5, 1'b1, 40, n);
      in_range("b5_lat", n, 13, 20);
      step(2);
      chk("b5_pulse", 32'(pulses - p0), 32'd1);
      chk("b5_last", 32'(ir_last_cell), 32'd5);
      chk("b5_any", 32'(ir_any), 32'd1);
      chk("b5_map", 32'(ir_in_p1), 32'h0020);
      ir_raw[5] = 1'b1;
      wait_bit(5, 1'b0, 60, n);
      in_range("b5_clr", n, 18, 26);

      // Box 2 hold stretch
      p0 = pulses;
      ir_raw[2] = 1'b0;
      wait_bit(2, 1'b1, 40, n);
      in_range("b2_lat", n, 13, 20);
      ir_raw[2] = 1'b1;
      wait_bit(2, 1'b0, 60, n);
      in_range("b2_hold", n, 18, 26);
      step(2);
      chk("b2_any0", 32'(ir_any), 32'd0);

      // Re-break during HOLD keeps the bit without a new pulse
      ir_raw[2] = 1'b0;
      wait_bit(2, 1'b1, 40, n);
      in_range("b2r_lat", n, 13, 20);
      step(2);
      p0 = pulses;
      ir_raw[2] = 1'b1;
      step(8);
      ir_raw[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (!ir_in_p1[2]) seen = 1'b1;
      end
      chk("b2r_drop", 32'(seen), 32'h0);
      chk("b2r_pulse", 32'(pulses - p0), 32'd0);
      ir_raw[2] = 1'b1;
      wait_bit(2, 1'b0, 60, n);
      in_range("b2r_clr", n, 18, 26);

      // Simultaneous boxes 9 and 3
      p0 = pulses;
      ir_raw[9] = 1'b0;
      ir_raw[3] = 1'b0;
      wait_bit(3, 1'b1, 40, n);
      in_range("b93_lat", n, 13, 20);
      chk("b93_map", 32'(ir_in_p1), 32'h0208);
      step(2);
      chk("b93_pulse", 32'(pulses - p0), 32'd1);
      chk("b93_last", 32'(ir_last_cell), 32'd3);
      ir_raw = 16'hFFFF;
      step(40);
      chk("b93_clr", 32'(ir_in_p1), 32'h0);

      // enable low while box 7 in HOLD
      ir_raw[7] = 1'b0;
      wait_bit(7, 1'b1, 40, n);
      in_range("b7_lat", n, 13, 20);
      step(2);
      ir_raw[7] = 1'b1;
      step(8);
      chk("b7_inhold", 32'(ir_in_p1[7]), 32'd1);
      p0 = pulses;
      enable = 1'b0;
      step(2);
      chk("en_off", 32'(ir_in_p1[7]), 32'd0);
      step(3);
      chk("en_pulse", 32'(pulses - p0), 32'd0);
      enable = 1'b1;

      // reset while box 7 in HOLD
      ir_raw[7] = 1'b0;
      wait_bit(7, 1'b1, 40, n);
      in_range("b7r_lat", n, 13, 20);
      step(2);
      ir_raw[7] = 1'b1;
      step(8);
      p0 = pulses;
      reset = 1'b1;
      step(2);
      chk("rst_hold", 32'(ir_in_p1[7]), 32'd0);
      reset = 1'b0;
      step(3);
      chk("rst_hpulse", 32'(pulses - p0), 32'd0);
      chk("rst_hlast", 32'(ir_last_cell), 32'd0);

      // reset mid-QUAL with beam held: full re-qualification
      ir_raw[5] = 1'b0;
      step(8);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      wait_bit(5, 1'b1, 40, n);
      in_range("req_lat", n, 13, 20);
      ir_raw[5] = 1'b1;
      step(40);
      chk("req_clr", 32'(ir_in_p1), 32'h0);

`ifdef IR_GRID_MASK_EN
      // Mask box 7 only while boxes 7 and 8 are in HOLD
      ir_raw[7] = 1'b0;
      ir_raw[8] = 1'b0;
      wait_bit(7, 1'b1, 40, n);
      in_range("m_lat", n, 13, 20);
      step(2);
      ir_raw[7] = 1'b1;
      ir_raw[8] = 1'b1;
      step(8);
      ir_mask[7] = 1'b1;
      step(2);
      chk("m_map", 32'(ir_in_p1), 32'h0100);
      ir_mask[7] = 1'b0;
      step(40);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
